// File: rtl/csa_pkg.sv
// Shared state encoding, default sizes and elaboration helpers for the
// carry-save frame accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEF_W     = 32'sd4;
  localparam int DEF_N     = 32'sd4;
  localparam int DEF_ACC_W = 32'sd8;
  localparam int DEF_CNT_W = 32'sd8;

  // Number of vectors still alive after lvl levels of 3:2 compression of m vectors.
  function automatic int level_count(input int m, input int lvl);
    int k;
    k = m;
    for (int i = 32'sd0; i < lvl; i++) begin
      if (k > 32'sd2) begin
        k = (32'sd2 * (k / 32'sd3)) + (k % 32'sd3);
      end
    end
    return k;
  endfunction

  function automatic int tree_depth(input int m);
    int k;
    int d;
    k = m;
    d = 32'sd0;
    while (k > 32'sd2) begin
      k = (32'sd2 * (k / 32'sd3)) + (k % 32'sd3);
      d = d + 32'sd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/csa_fa.sv
// Single-bit full adder used by the 3:2 compression tree.
module csa_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_rca.sv
// Ripple-carry adder that resolves the carry-save pair once per frame.
module csa_rca #(
  parameter int WIDTH = 32'sd8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin
    logic c;
    c = 1'b0;
    s = '0;
    for (int i = 32'sd0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/csa_tree.sv
// Wallace-style reduction of M vectors to a sum/carry pair; drop flags any
// carry bit shifted out past the MSB.
module csa_tree
  import csa_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int M     = DEF_N + 32'sd2
) (
  input  logic [M-1:0][ACC_W-1:0] vecs,
  output logic [ACC_W-1:0]        sum,
  output logic [ACC_W-1:0]        carry,
  output logic                    drop
);

  localparam int DEPTH = tree_depth(M);

  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int K  = level_count(M, l);
    localparam int G  = K / 32'sd3;
    localparam int KN = level_count(M, l + 32'sd1);

    logic [K-1:0][ACC_W-1:0]  src_s;
    logic [KN-1:0][ACC_W-1:0] nxt_s;
    logic [G-1:0]             drp_s;
    logic                     dacc_s;

    if (l == 0) begin : g_first
      assign src_s  = vecs;
      assign dacc_s = |drp_s;
    end else begin : g_rest
      assign src_s  = g_lvl[l-1].nxt_s;
      assign dacc_s = g_lvl[l-1].dacc_s | (|drp_s);
    end

    for (genvar g = 0; g < G; g++) begin : g_grp
      logic [ACC_W-1:0] maj_s;
      for (genvar k = 0; k < ACC_W; k++) begin : g_bit
        csa_fa u_fa (
          .a   (src_s[32'sd3*g][k]),
          .b   (src_s[32'sd3*g + 32'sd1][k]),
          .cin (src_s[32'sd3*g + 32'sd2][k]),
          .s   (nxt_s[32'sd2*g][k]),
          .cout(maj_s[k])
        );
      end
      assign nxt_s[32'sd2*g + 32'sd1] = {maj_s[ACC_W-2:0], 1'b0};
      assign drp_s[g]                 = maj_s[ACC_W-1];
    end

    // Leftover vectors that did not fill a group skip this level.
    for (genvar r = 0; r < K - 32'sd3*G; r++) begin : g_pass
      assign nxt_s[32'sd2*G + r] = src_s[32'sd3*G + r];
    end
  end

  assign sum   = g_lvl[DEPTH-1].nxt_s[0];
  assign carry = g_lvl[DEPTH-1].nxt_s[1];
  assign drop  = g_lvl[DEPTH-1].dacc_s;

endmodule

// File: rtl/csa_accum.sv
// Multi-operand frame accumulator: beats are folded into a carry-save pair,
// resolved once per frame and offered on a valid/ready result port.
module csa_accum
  import csa_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam int M = N + 32'sd2;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ACC_W-1:0]        sum_r;
  logic [ACC_W-1:0]        carry_r;
  logic                    ovf_r;
  logic [CNT_W-1:0]        count_r;
  logic [ACC_W-1:0]        out_sum_r;
  logic                    out_ovf_r;
  logic [CNT_W-1:0]        out_count_r;
  logic                    accept_s;
  logic [M-1:0][ACC_W-1:0] vecs_s;
  logic [ACC_W-1:0]        tree_sum_s;
  logic [ACC_W-1:0]        tree_carry_s;
  logic                    tree_drop_s;
  logic [ACC_W-1:0]        rca_sum_s;
  logic                    rca_cout_s;

  assign in_ready  = (state_r == ACC) && !rst;
  assign out_valid = (state_r == HOLD) && !rst;
  assign accept_s  = in_valid && in_ready;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;
  assign out_count = out_count_r;

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign vecs_s[i] = ACC_W'(in_data[i*W +: W]);
  end
  assign vecs_s[N]          = sum_r;
  assign vecs_s[N + 32'sd1] = carry_r;

  csa_tree #(
    .ACC_W(ACC_W),
    .M    (M)
  ) u_tree (
    .vecs (vecs_s),
    .sum  (tree_sum_s),
    .carry(tree_carry_s),
    .drop (tree_drop_s)
  );

  csa_rca #(
    .WIDTH(ACC_W)
  ) u_rca (
    .a   (sum_r),
    .b   (carry_r),
    .s   (rca_sum_s),
    .cout(rca_cout_s)
  );

  // Next-state decode for the ACC -> RESOLVE -> HOLD frame cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACC: begin
        if (accept_s && in_last) begin
          state_nxt_s = RESOLVE;
        end else begin
          state_nxt_s = ACC;
        end
      end
      RESOLVE: state_nxt_s = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulator pair, overflow sticky, beat counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= '0;
      carry_r     <= '0;
      ovf_r       <= 1'b0;
      count_r     <= '0;
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
      out_count_r <= '0;
    end else begin
      case (state_r)
        ACC: begin
          if (accept_s) begin
            sum_r   <= tree_sum_s;
            carry_r <= tree_carry_s;
            ovf_r   <= ovf_r | tree_drop_s;
            if (count_r != '1) begin
              count_r <= count_r + CNT_W'(1'b1);
            end
          end
        end
        RESOLVE: begin
          out_sum_r   <= rca_sum_s;
          out_ovf_r   <= ovf_r | rca_cout_s;
          out_count_r <= count_r;
        end
        HOLD: begin
          if (out_ready) begin
            sum_r   <= '0;
            carry_r <= '0;
            ovf_r   <= 1'b0;
            count_r <= '0;
          end
        end
        default: begin
          sum_r   <= '0;
          carry_r <= '0;
          ovf_r   <= 1'b0;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum: directed frames from the test plan plus
// randomized frames scored against an integer-arithmetic reference.
module tb_csa_accum;

  localparam int W     = 4;
  localparam int N     = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int DW    = N * W;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] beat_q[$];

  csa_accum #(.W(W), .N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  // Reference: true integer total of every operand in beat_q.
  function automatic void model(output logic [ACC_W-1:0] s, output logic o,
                                output logic [CNT_W-1:0] c);
    int t;
    logic [DW-1:0] v;
    t = 0;
    foreach (beat_q[b]) begin
      v = beat_q[b];
      for (int i = 0; i < N; i++) t += int'(v[i*W +: W]);
    end
    s = ACC_W'(t % (1 << ACC_W));
    o = (t >= (1 << ACC_W));
    c = (beat_q.size() > MAXC) ? CNT_W'(MAXC) : CNT_W'(beat_q.size());
  endfunction

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    in_last  = 1'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int max_gap, input bit end_frame);
    int gap;
    for (int b = 0; b < beat_q.size(); b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) idle_cycle();
      in_valid = 1'b1;
      in_data  = beat_q[b];
      in_last  = end_frame && (b == beat_q.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid === 1'b1) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%0d ovf=%b cnt=%0d, required all 0",
               in_ready, out_valid, out_sum, out_ovf, out_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_beat();
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec;
    beat_q.delete();
    beat_q.push_back(pack(4'd1, 4'd2, 4'd3, 4'd4));
    model(es, eo, ec);
    out_ready = 1'b1;
    send_frame(0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_resolve: vld=%b rdy=%b, required 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: vld=%b, required 1 two cycles after accept", out_valid);
    end
    checks++;
    if (out_sum !== es || out_ovf !== eo || out_count !== ec) begin
      errors++;
      $display("FAIL single_result: sum=%0d ovf=%b cnt=%0d, required %0d %b %0d",
               out_sum, out_ovf, out_count, es, eo, ec);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back(input int beats, input logic [DW-1:0] extra, input bit use_extra,
                                   input string name);
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec; bit ok;
    beat_q.delete();
    for (int b = 0; b < beats; b++) beat_q.push_back(pack(4'd15, 4'd15, 4'd15, 4'd15));
    if (use_extra) beat_q.push_back(extra);
    model(es, eo, ec);
    send_frame(0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b, required 1", name, out_valid);
    end
    checks++;
    if (out_sum !== es || out_ovf !== eo || out_count !== ec) begin
      errors++;
      $display("FAIL %s: sum=%0d ovf=%b cnt=%0d, required %0d %b %0d",
               name, out_sum, out_ovf, out_count, es, eo, ec);
    end
    handshake();
  endtask

  task automatic test_hold_stall();
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec; bit ok;
    beat_q.delete();
    beat_q.push_back(DW'($urandom));
    beat_q.push_back(DW'($urandom));
    model(es, eo, ec);
    send_frame(0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: out_valid=%b, required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = DW'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== es || out_ovf !== eo || out_count !== ec) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b sum=%0d ovf=%b cnt=%0d, required 1 0 %0d %b %0d",
                 i, out_valid, in_ready, out_sum, out_ovf, out_count, es, eo, ec);
      end
    end
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
    beat_q.delete();
    beat_q.push_back(pack(4'd0, 4'd0, 4'd0, 4'd1));
    model(es, eo, ec);
    send_frame(0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || out_sum !== es || out_ovf !== eo || out_count !== ec) begin
      errors++;
      $display("FAIL stall_next_frame: sum=%0d ovf=%b cnt=%0d, required %0d %b %0d",
               out_sum, out_ovf, out_count, es, eo, ec);
    end
    handshake();
  endtask

  task automatic test_reset_midframe();
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec; bit ok;
    beat_q.delete();
    beat_q.push_back(pack(4'd9, 4'd9, 4'd9, 4'd9));
    beat_q.push_back(pack(4'd7, 4'd7, 4'd7, 4'd7));
    send_frame(0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; in_data = DW'($urandom);
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_during: rdy=%b vld=%b, required 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0 || out_count !== '0) begin
      errors++;
      $display("FAIL midrst_after: vld=%b sum=%0d ovf=%b cnt=%0d, required all 0",
               out_valid, out_sum, out_ovf, out_count);
    end
    beat_q.delete();
    beat_q.push_back(pack(4'd1, 4'd1, 4'd1, 4'd1));
    model(es, eo, ec);
    send_frame(0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || out_sum !== es || out_ovf !== eo || out_count !== ec) begin
      errors++;
      $display("FAIL midrst_frame: sum=%0d ovf=%b cnt=%0d, required %0d %b %0d",
               out_sum, out_ovf, out_count, es, eo, ec);
    end
    handshake();
  endtask

  task automatic test_gaps();
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec; bit ok;
    beat_q.delete();
    beat_q.push_back(pack(4'd1, 4'd2, 4'd3, 4'd4));
    beat_q.push_back(pack(4'd5, 4'd6, 4'd7, 4'd8));
    model(es, eo, ec);
    for (int pass = 0; pass < 2; pass++) begin
      send_frame((pass == 0) ? 0 : 3, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok || out_sum !== es || out_ovf !== eo || out_count !== ec) begin
        errors++;
        $display("FAIL gaps_pass%0d: sum=%0d ovf=%b cnt=%0d, required %0d %b %0d",
                 pass, out_sum, out_ovf, out_count, es, eo, ec);
      end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec; bit ok;
    int nb;
    for (int f = 0; f < 12; f++) begin
      beat_q.delete();
      nb = int'($urandom_range(6, 1));
      for (int b = 0; b < nb; b++) beat_q.push_back(DW'($urandom));
      model(es, eo, ec);
      send_frame(3, 1'b1);
      wait_valid(ok);
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk); #1;
      end
      checks++;
      if (!ok || out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo || out_count !== ec) begin
        errors++;
        $display("FAIL random_frame%0d: vld=%b sum=%0d ovf=%b cnt=%0d, required 1 %0d %b %0d",
                 f, out_valid, out_sum, out_ovf, out_count, es, eo, ec);
      end
      handshake();
    end
  endtask

  task automatic test_saturation();
    logic [ACC_W-1:0] es; logic eo; logic [CNT_W-1:0] ec; bit ok;
    beat_q.delete();
    for (int b = 0; b < MAXC + 2; b++) beat_q.push_back(DW'($urandom));
    model(es, eo, ec);
    send_frame(0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || out_sum !== es || out_ovf !== eo || out_count !== ec) begin
      errors++;
      $display("FAIL count_saturate: sum=%0d ovf=%b cnt=%0d, required %0d %b %0d",
               out_sum, out_ovf, out_count, es, eo, ec);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back(3, '0, 1'b0, "b2b_180");
    test_back_to_back(5, '0, 1'b0, "ovf_300");
    test_back_to_back(4, pack(4'd15, 4'd0, 4'd0, 4'd0), 1'b1, "edge_255");
    test_back_to_back(4, pack(4'd4, 4'd4, 4'd4, 4'd4), 1'b1, "edge_256");
    test_hold_stall();
    test_reset_midframe();
    test_gaps();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
